// File: rtl/exit_monitor.sv
// exit_monitor: times a program run in clock cycles and captures its exit code.
//
// The block watches the exit word written by the control-register block.
// It counts RUN cycles and latches the exit code on the first exit strobe.
// An optional watchdog ends the run if no strobe arrives in time.
// The result is handed over through a valid/ready end-of-computation (EOC) handshake.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous reset, active-high
//   exit_i       [0] = exit write strobe, [DataWidth-1:1] = exit code
//   enable_i     level; high arms a run, low returns to idle
//   eoc_valid_o  EOC result valid (state REPORT)
//   eoc_ready_i  EOC result accepted
//   exit_code_o  captured exit code (0 on watchdog timeout)
//   timeout_o    result was produced by the watchdog
//   cycle_cnt_o  RUN cycles counted (saturating)
//   busy_o       FSM in RUN
//   done_o       FSM in DONE
//   overrun_o    sticky: exit strobe seen outside RUN, cleared on RUN entry
module exit_monitor #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned CntWidth      = 64,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] exit_i,
  input  logic                 enable_i,
  output logic                 eoc_valid_o,
  input  logic                 eoc_ready_i,
  output logic [DataWidth-2:0] exit_code_o,
  output logic                 timeout_o,
  output logic [CntWidth-1:0]  cycle_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o
);

  typedef enum logic [1:0] {StIdle, StRun, StReport, StDone} state_e;

  localparam bit WdogEn = (TimeoutCycles != 0);
  // Count value seen in the last allowed RUN cycle; only meaningful when WdogEn is set.
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  state_e state_q, state_d;

  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [DataWidth-2:0] code_q, code_d;
  logic                 timeout_q, timeout_d;
  logic                 overrun_q, overrun_d;

  logic                 strobe;
  logic [DataWidth-2:0] code_in;
  logic                 timeout_hit;

  assign strobe      = exit_i[0];
  assign code_in     = exit_i[DataWidth-1:1];
  assign timeout_hit = WdogEn && (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; strobe beats timeout, timeout beats abort
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) state_d = StRun;
      end
      StRun: begin
        if (strobe)           state_d = StReport;
        else if (timeout_hit) state_d = StReport;
        else if (!enable_i)   state_d = StIdle;
      end
      StReport: begin
        if (eoc_ready_i) state_d = StDone;
      end
      StDone: begin
        if (!enable_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Result datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    code_d    = code_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          cnt_d     = '0;
          code_d    = '0;
          timeout_d = 1'b0;
          overrun_d = 1'b0;
        end
      end
      StRun: begin
        // Saturate rather than wrap so a runaway run still reads as "very long"
        if (cnt_q != {CntWidth{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (strobe) begin
          code_d    = code_in;
          timeout_d = 1'b0;
        end else if (timeout_hit) begin
          code_d    = '0;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A strobe outside RUN is recorded even in the cycle that enters RUN
    if (strobe && (state_q != StRun)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      code_q    <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs: registered values or decodes of the state register
  always_comb begin
    eoc_valid_o = (state_q == StReport);
    busy_o      = (state_q == StRun);
    done_o      = (state_q == StDone);
    exit_code_o = code_q;
    timeout_o   = timeout_q;
    cycle_cnt_o = cnt_q;
    overrun_o   = overrun_q;
  end

endmodule

// File: tb/tb_exit_monitor.sv
module tb_exit_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] exit_w = '0;
  logic        ready = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

  // Instance a: watchdog 10, 64-bit counter
  logic        valid_a, timeout_a, busy_a, done_a, ovr_a;
  logic [30:0] code_a;
  logic [63:0] cnt_a;
  // Instance b: watchdog 100
  logic        valid_b, timeout_b, busy_b, done_b, ovr_b;
  logic [30:0] code_b;
  logic [63:0] cnt_b;
  // Instance c: 4-bit counter, no watchdog
  logic        valid_c, timeout_c, busy_c, done_c, ovr_c;
  logic [30:0] code_c;
  logic [3:0]  cnt_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exit_monitor #(.DataWidth(32), .CntWidth(64), .TimeoutCycles(10)) dut_a (
    .clk_i(clk), .rst_i(rst), .exit_i(exit_w), .enable_i(en_a),
    .eoc_valid_o(valid_a), .eoc_ready_i(ready), .exit_code_o(code_a),
    .timeout_o(timeout_a), .cycle_cnt_o(cnt_a), .busy_o(busy_a),
    .done_o(done_a), .overrun_o(ovr_a)
  );

  exit_monitor #(.DataWidth(32), .CntWidth(64), .TimeoutCycles(100)) dut_b (
    .clk_i(clk), .rst_i(rst), .exit_i(exit_w), .enable_i(en_b),
    .eoc_valid_o(valid_b), .eoc_ready_i(ready), .exit_code_o(code_b),
    .timeout_o(timeout_b), .cycle_cnt_o(cnt_b), .busy_o(busy_b),
    .done_o(done_b), .overrun_o(ovr_b)
  );

  exit_monitor #(.DataWidth(32), .CntWidth(4), .TimeoutCycles(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .exit_i(exit_w), .enable_i(en_c),
    .eoc_valid_o(valid_c), .eoc_ready_i(ready), .exit_code_o(code_c),
    .timeout_o(timeout_c), .cycle_cnt_o(cnt_c), .busy_o(busy_c),
    .done_o(done_c), .overrun_o(ovr_c)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive and sample only at falling edges
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // {valid, busy, done, timeout, overrun} for instance a
  function automatic logic [4:0] flags_a();
    return {valid_a, busy_a, done_a, timeout_a, ovr_a};
  endfunction

  initial begin
    // Reset state
    #2 rst = 1'b1;
    #2;
    check("reset_flags_a", 128'(flags_a()), 128'(5'b00000));
    check("reset_code_a",  128'(code_a), 128'(0));
    check("reset_cnt_a",   128'(cnt_a), 128'(0));
    check("reset_flags_b", 128'({valid_b, busy_b, done_b, timeout_b, ovr_b}), 128'(0));
    check("reset_flags_c", 128'({valid_c, busy_c, done_c, timeout_c, ovr_c, cnt_c}), 128'(0));
    step();
    rst = 1'b0;

    // 1: strobe code 0x2A on the 5th RUN cycle
    en_a = 1'b1;
    step();                                   // RUN cycle 1
    check("t1_run_entry", 128'({busy_a, cnt_a}), {63'd0, 1'b1, 64'd0});
    step(4);                                  // RUN cycle 5
    exit_w = {31'h2A, 1'b1};
    step();
    exit_w = '0;
    check("t1_flags", 128'(flags_a()), 128'(5'b10000));
    check("t1_code",  128'(code_a), 128'(32'h2A));
    check("t1_cnt",   128'(cnt_a), 128'(5));
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t1_done", 128'(flags_a()), 128'(5'b00100));
    en_a = 1'b0;
    step();
    check("t1_idle", 128'({flags_a(), cnt_a}), {59'd0, 5'b00000, 64'd5});

    // Abort after 3 RUN cycles, then a strobe while idle
    en_a = 1'b1;
    step(3);                                  // RUN cycle 3
    en_a = 1'b0;
    step();
    check("abort_state", 128'({flags_a(), cnt_a}), {59'd0, 5'b00000, 64'd3});
    exit_w = {31'h1, 1'b1};
    step();
    exit_w = '0;
    check("idle_overrun", 128'({flags_a(), code_a}), {92'd0, 5'b00001, 31'd0});

    // 3: strobe in the 10th RUN cycle coincides with watchdog expiry
    en_a = 1'b1;
    step();                                   // RUN cycle 1, overrun cleared
    check("t3_entry_ovr", 128'({busy_a, ovr_a}), 128'(2'b10));
    step(9);                                  // RUN cycle 10
    check("t3_still_run", 128'({busy_a, cnt_a}), {63'd0, 1'b1, 64'd9});
    exit_w = {31'h3, 1'b1};
    step();
    exit_w = '0;
    check("t3_flags", 128'(flags_a()), 128'(5'b10000));
    check("t3_code_cnt", 128'({code_a, cnt_a}), {33'd0, 31'd3, 64'd10});
    ready = 1'b1;
    step();
    ready = 1'b0;
    en_a = 1'b0;
    step();

    // Watchdog on instance a alone: 10 RUN cycles without strobe
    en_a = 1'b1;
    step(11);
    check("wd10_flags", 128'(flags_a()), 128'(5'b10010));
    check("wd10_code_cnt", 128'({code_a, cnt_a}), {33'd0, 31'd0, 64'd10});
    ready = 1'b1;
    step();
    ready = 1'b0;
    en_a = 1'b0;
    step();

    // 4: ready held low for 20 cycles while enable toggles and a strobe arrives
    en_a = 1'b1;
    step(3);                                  // RUN cycle 3
    exit_w = {31'h11, 1'b1};
    step();
    exit_w = '0;
    for (int i = 0; i < 20; i++) begin
      en_a = ~en_a;
      exit_w = (i == 5) ? {31'h7F, 1'b1} : 32'd0;
      check("t4_hold", 128'({valid_a, done_a, timeout_a, code_a, cnt_a}),
            {30'd0, 3'b100, 31'h11, 64'd3});
      step();
    end
    exit_w = '0;
    check("t4_overrun", 128'({valid_a, ovr_a, code_a}), {95'd0, 2'b11, 31'h11});
    en_a = 1'b0;
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("t4_done", 128'({flags_a(), code_a, cnt_a}), {28'd0, 5'b00101, 31'h11, 64'd3});
    step();
    check("t4_idle", 128'({busy_a, done_a}), 128'(2'b00));

    // 6: reset in REPORT clears everything at once; next run starts clean
    en_a = 1'b1;
    step(2);                                  // RUN cycle 2
    exit_w = {31'h5, 1'b1};
    step();                                   // REPORT; this strobe is cleared below
    exit_w = {31'h6, 1'b1};
    step();
    exit_w = '0;
    check("t6_pre", 128'({flags_a(), code_a}), {92'd0, 5'b10001, 31'h5});
    #1 rst = 1'b1;
    #1;
    check("t6_reset_flags", 128'(flags_a()), 128'(5'b00000));
    check("t6_reset_data",  128'({code_a, cnt_a}), 128'(0));
    step();
    rst = 1'b0;
    step();                                   // IDLE->RUN on this edge
    check("t6_rerun", 128'({flags_a(), cnt_a}), {59'd0, 5'b01000, 64'd0});
    en_a = 1'b0;
    step();

    // 2: watchdog 100, no strobe
    en_b = 1'b1;
    step(100);                                // RUN cycle 100
    check("t2_before", 128'({valid_b, busy_b, cnt_b}), {62'd0, 2'b01, 64'd99});
    step();
    check("t2_flags", 128'({valid_b, busy_b, timeout_b}), 128'(3'b101));
    check("t2_code_cnt", 128'({code_b, cnt_b}), {33'd0, 31'd0, 64'd100});
    ready = 1'b1;
    step();
    ready = 1'b0;
    en_b = 1'b0;
    check("t2_done", 128'({valid_b, done_b}), 128'(2'b01));
    step();

    // 5: 4-bit counter saturates
    en_c = 1'b1;
    step(20);                                 // RUN cycle 20
    check("t5_run", 128'({busy_c, valid_c, cnt_c}), {122'd0, 2'b10, 4'hF});
    step();                                   // RUN cycle 21
    exit_w = {31'h9, 1'b1};
    step();
    exit_w = '0;
    check("t5_result", 128'({valid_c, timeout_c, code_c, cnt_c}),
          {91'd0, 2'b10, 31'h9, 4'hF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
